// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with a valid/ready handshake, synchronous flush and
// a saturating stall counter. It carries a control field and a data field
// between two pipeline stages. A flushed or reset stage holds an all-zero
// control field, so a bubble decodes as a NOP downstream.
//
// Build option (macro PIPE_SKID_EN):
//   defined   - two-entry skid buffer, three-state FSM (EMPTY/ONE/TWO).
//               in_ready comes straight from a flop, so there is no
//               combinational path from out_ready to in_ready.
//   undefined - single register, two-state FSM (EMPTY/FULL). in_ready is
//               combinational: !out_valid || out_ready.
//
// Parameters:
//   CTRL_W - control field width (cleared on reset and flush)
//   DATA_W - data field width (cleared on reset, held on flush)
//   CNT_W  - stall counter width
//
// Ports:
//   reloj      in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   flush      in   synchronous flush, empties the stage on this edge
//   in_valid   in   upstream word valid
//   in_ready   out  stage can accept a word this cycle
//   in_ctrl    in   upstream control field
//   in_data    in   upstream data field
//   out_valid  out  output word valid
//   out_ready  in   downstream accepts the output word this cycle
//   out_ctrl   out  registered control field
//   out_data   out  registered data field
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 106,
  parameter int CNT_W  = 16
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept;
  logic              emit;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  assign out_ctrl = main_ctrl_reg;
  assign out_data = main_data_reg;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              in_ready_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Flush wins over accept and emit; any word offered this cycle is lost.
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the main word.
            state_next = ST_TWO;
            load_skid  = 1'b1;
          end else if (emit) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered copy of (state != TWO) so in_ready never sees out_ready.
      in_ready_reg <= (state_next != ST_TWO);

      if (load_main_in) begin
        main_data_reg <= in_data;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
      end

      if (flush) begin
        main_ctrl_reg <= '0;
      end else if (load_main_in) begin
        main_ctrl_reg <= in_ctrl;
      end else if (load_main_skid) begin
        main_ctrl_reg <= skid_ctrl_reg;
      end

      if (load_skid) begin
        skid_data_reg <= in_data;
      end

      if (flush) begin
        skid_ctrl_reg <= '0;
      end else if (load_skid) begin
        skid_ctrl_reg <= in_ctrl;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);

`else

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   load_main;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else if (accept) begin
      state_next = ST_FULL;
      load_main  = 1'b1;
    end else if (emit) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main) begin
        main_data_reg <= in_data;
      end
      if (flush) begin
        main_ctrl_reg <= '0;
      end else if (load_main) begin
        main_ctrl_reg <= in_ctrl;
      end
    end
  end

  // The stage can take a word when empty or when its word leaves this cycle.
  assign in_ready  = !out_valid || out_ready;
  assign out_valid = (state_reg == ST_FULL);

`endif

  // Stall accounting ignores flush; only reset clears it.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 106;
  localparam int NW = 16;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  // Second instance with a 2-bit counter for the saturation check.
  logic       b_flush;
  logic       b_valid;
  logic       b_in_ready;
  logic [3:0] b_ctrl;
  logic [7:0] b_data;
  logic       b_out_valid;
  logic       b_ready;
  logic [3:0] b_out_ctrl;
  logic [7:0] b_out_data;
  logic [1:0] b_stall;

  int err_cnt  = 0;
  int chk_cnt  = 0;
  int emit_cnt = 0;

  logic [CW+DW-1:0] sb_q[$];

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .reloj    (clk),
    .reset    (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .CNT_W(2)) dut2 (
    .reloj    (clk),
    .reset    (rst),
    .flush    (b_flush),
    .in_valid (b_valid),
    .in_ready (b_in_ready),
    .in_ctrl  (b_ctrl),
    .in_data  (b_data),
    .out_valid(b_out_valid),
    .out_ready(b_ready),
    .out_ctrl (b_out_ctrl),
    .out_data (b_out_data),
    .stall_cnt(b_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on emit, all sampled at the
  // falling edge so the handshake seen here is the one the next rising edge
  // will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        emit_cnt++;
        $display("emit ctrl=%0h data=%0h", out_ctrl, out_data);
        check_eq("sb_avail", 128'(sb_q.size() > 0), 128'd1);
        if (sb_q.size() > 0) begin
          check_eq("sb_word", {out_ctrl, out_data}, sb_q.pop_front());
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [CW-1:0] wc[3];
  logic [DW-1:0] wd[3];
  logic [NW-1:0] stall_before;
  int            idx;
  int            emit_base;
  logic          acc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    b_flush = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_ctrl = '0; b_data = '0;

    // Reset state
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_stall", stall_cnt, 0);
    check_eq("rst_ctrl", out_ctrl, 0);
    @(negedge clk); #2 rst = 1'b0;
    cyc();

    // Stream 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_valid = (i <= 8);
      in_ctrl  = CW'(i);
      in_data  = DW'(i);
      @(negedge clk);
      if (i >= 2) begin
        check_eq("lat_valid", out_valid, 1);
        check_eq("lat_data", out_data, 128'(i - 1));
      end
      if (i <= 8) check_eq("strm_rdy", in_ready, 1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("strm_idle", out_valid, 0);
    check_eq("strm_stall", stall_cnt, 0);
    cyc();

    // Asynchronous reset while a word is held
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 10'h3; in_data = 106'h5a5a;
    cyc(); cyc();
    @(negedge clk);
    check_eq("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_ctrl", out_ctrl, 0);
    check_eq("arst_data", out_data, 0);
    check_eq("arst_stall", stall_cnt, 0);
    check_eq("arst_ready", in_ready, 1);
    sb_q.delete();
    in_valid = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    cyc();

    // Back-pressure: offer A, B, C with out_ready low for four cycles
    wc[0] = 10'h0a1; wd[0] = 106'haaaa;
    wc[1] = 10'h0b2; wd[1] = 106'hbbbb;
    wc[2] = 10'h0c3; wd[2] = 106'hcccc;
    idx = 0; emit_base = emit_cnt; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      in_ctrl  = wc[idx % 3];
      in_data  = wd[idx % 3];
      @(negedge clk);
      acc = in_valid && in_ready;
      check_eq("bp_rdy", in_ready, SKID ? (c < 2) : (c < 1));
      cyc();
      if (acc) idx++;
    end
    out_ready = 1'b1;
    in_valid  = (idx < 3);
    in_ctrl   = wc[idx % 3];
    in_data   = wd[idx % 3];
    @(negedge clk);
    acc = in_valid && in_ready;
    check_eq("rdy_follow", in_ready, SKID ? 0 : 1);
    check_eq("bp_hold", out_data, wd[0]);
    cyc();
    if (acc) idx++;
    for (int k = 0; k < 20; k++) begin
      if ((emit_cnt - emit_base) >= 3 && idx == 3) break;
      in_valid = (idx < 3);
      in_ctrl  = wc[idx % 3];
      in_data  = wd[idx % 3];
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("bp_emits", emit_cnt - emit_base, 3);
    @(negedge clk);
    check_eq("bp_stall", stall_cnt, 3);
    check_eq("bp_idle", out_valid, 0);
    cyc();

    // Flush with a full stage (TWO in skid mode) while a word is offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h111; in_data = 106'h1111;
    @(negedge clk);
    acc = in_ready;
    cyc();
    if (acc) begin
      in_ctrl = 10'h122; in_data = 106'h2222;
    end
    @(negedge clk);
    cyc();
    flush = 1'b1; out_ready = 1'b1;
    in_ctrl = 10'h133; in_data = 106'h3333;
    @(negedge clk);
    check_eq("fl_pre_valid", out_valid, 1);
    stall_before = stall_cnt;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_ctrl", out_ctrl, 0);
    check_eq("fl_stall", stall_cnt, stall_before);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("fl_drop", out_valid, 0);
      cyc();
    end

    // 2-bit stall counter saturation
    b_valid = 1'b1; b_ready = 1'b0; b_ctrl = 4'h5; b_data = 8'hc3;
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    check_eq("cnt2_start", b_stall, 0);
    cyc();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_eq("cnt2_sat", b_stall, (j + 1 > 3) ? 3 : j + 1);
      cyc();
    end
    @(negedge clk);
    check_eq("cnt2_valid", b_out_valid, 1);
    check_eq("cnt2_data", b_out_data, 8'hc3);
    check_eq("cnt2_ctrl", b_out_ctrl, 4'h5);
    b_ready = 1'b1;
    cyc();

    @(negedge clk);
    check_eq("sb_left", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
